// File: rtl/jtpopeye_sync_decode.sv
// Video sync decoder: measures line/frame totals from HS/VS, derives the
// active-area pixel/line position from HB/VB and tracks whether the incoming
// timing has been stable long enough to be trusted (locked).
module jtpopeye_sync_decode #(
   parameter int HW          = 9,
   parameter int VW          = 10,
   parameter int LOCK_FRAMES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pxl_cen,
   input  logic          HS,
   input  logic          VS,
   input  logic          HB,
   input  logic          VB,
   output logic [HW-1:0] hpos,
   output logic [VW-1:0] vpos,
   output logic          active,
   output logic [HW-1:0] htotal,
   output logic [VW-1:0] vtotal,
   output logic          frame_start,
   output logic          locked
);

   localparam int MW = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);

   localparam logic [1:0] ST_SEARCH = 2'd0;
   localparam logic [1:0] ST_CHECK  = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   // sampled sync/blank inputs, one pxl_cen behind the pins
   logic          hs_p0, vs_p0, hb_p0, vb_p0;

   logic [HW-1:0] hcnt;
   logic [VW-1:0] lcnt;
   logic [MW-1:0] match;
   logic          line_err;
   logic [1:0]    state;

   logic          hs_rise, vs_rise, hb_rise, hb_fall, vb_fall;
   logic [HW-1:0] hlen;
   logic [VW-1:0] lcnt_inc, vlen;
   logic [MW-1:0] match_inc;
   logic          len_err, err_now, vt_same, timeout, lock_hit;

   function automatic logic [HW-1:0] sat_inc_h(input logic [HW-1:0] v);
      return (v == {HW{1'b1}}) ? v : v + 1'b1;
   endfunction

   function automatic logic [VW-1:0] sat_inc_v(input logic [VW-1:0] v);
      return (v == {VW{1'b1}}) ? v : v + 1'b1;
   endfunction

   function automatic logic [MW-1:0] sat_inc_m(input logic [MW-1:0] v);
      return (v == {MW{1'b1}}) ? v : v + 1'b1;
   endfunction

   // Edges are only meaningful on pixel-enable cycles and act immediately.
   assign hs_rise   = pxl_cen &  HS & ~hs_p0;
   assign vs_rise   = pxl_cen &  VS & ~vs_p0;
   assign hb_rise   = pxl_cen &  HB & ~hb_p0;
   assign hb_fall   = pxl_cen & ~HB &  hb_p0;
   assign vb_fall   = pxl_cen & ~VB &  vb_p0;

   // Length of the line just closed, and frame length including a line
   // that closes on the same pixel as the VS edge.
   assign hlen      = sat_inc_h(hcnt);
   assign lcnt_inc  = sat_inc_v(lcnt);
   assign vlen      = hs_rise ? lcnt_inc : lcnt;

   // A line-length error on the very HS edge that coincides with VS still
   // counts towards this frame's verdict.
   assign len_err   = hs_rise & (state != ST_SEARCH) & (hlen != htotal);
   assign err_now   = line_err | len_err;
   assign vt_same   = (vlen == vtotal);
   assign match_inc = sat_inc_m(match);
   assign lock_hit  = (int'(match_inc) >= LOCK_FRAMES);

   // A counter pinned at all-ones means the sync it waits for has vanished.
   assign timeout   = (hcnt == {HW{1'b1}}) | (lcnt == {VW{1'b1}});

   assign locked    = (state == ST_LOCKED);

   // Input sampling, line/frame measurement and active-area position.
   always_ff @(posedge clk) begin
      if (rst) begin
         hs_p0       <= 1'b0;
         vs_p0       <= 1'b0;
         hb_p0       <= 1'b0;
         vb_p0       <= 1'b0;
         active      <= 1'b0;
         hcnt        <= '0;
         lcnt        <= '0;
         htotal      <= '0;
         vtotal      <= '0;
         hpos        <= '0;
         vpos        <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= vs_rise;
         if (pxl_cen) begin
            hs_p0  <= HS;
            vs_p0  <= VS;
            hb_p0  <= HB;
            vb_p0  <= VB;
            active <= ~HB & ~VB;

            if (hs_rise) begin
               htotal <= hlen;
               hcnt   <= '0;
            end else begin
               hcnt   <= hlen;
            end

            if (vs_rise) begin
               vtotal <= vlen;
               lcnt   <= '0;
            end else if (hs_rise) begin
               lcnt   <= lcnt_inc;
            end

            if (hb_fall)
               hpos <= '0;
            else if (!hb_p0)
               hpos <= sat_inc_h(hpos);

            if (vb_fall)
               vpos <= '0;
            else if (hb_rise && !vb_p0)
               vpos <= sat_inc_v(vpos);
         end
      end
   end

   // Lock tracking: a frame must repeat with clean lines before it is trusted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_SEARCH;
         match    <= '0;
         line_err <= 1'b0;
      end else begin
         if (vs_rise)
            line_err <= 1'b0;
         else if (len_err)
            line_err <= 1'b1;

         if (timeout) begin
            state <= ST_SEARCH;
            match <= '0;
         end else if (vs_rise) begin
            case (state)
               ST_SEARCH: begin
                  state <= ST_CHECK;
                  match <= '0;
               end
               ST_CHECK: begin
                  if (!err_now && vt_same) begin
                     match <= match_inc;
                     if (lock_hit)
                        state <= ST_LOCKED;
                  end else begin
                     match <= '0;
                  end
               end
               ST_LOCKED: begin
                  if (err_now || !vt_same) begin
                     state <= ST_SEARCH;
                     match <= '0;
                  end
               end
               default: begin
                  state <= ST_SEARCH;
                  match <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jtpopeye_sync_decode.sv
// Directed bench for jtpopeye_sync_decode using a reduced video raster
// (40 pixels/line, HS 4 wide, HB 8 pixels, 20 lines/frame, VS 1 line,
// VB 4 lines) so many frames fit in a short run. pxl_cen is high one clk
// in four. Expected: htotal=40, vtotal=20, max active hpos=31, vpos=15.
module tb_jtpopeye_sync_decode;

   localparam int HW    = 9;
   localparam int VW    = 10;
   localparam int LINE  = 40;
   localparam int FRAME = 20;
   localparam int HS_W  = 4;
   localparam int HB_W  = 8;
   localparam int VB_L  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pxl_cen = 1'b0;
   logic          HS = 1'b0, VS = 1'b0, HB = 1'b0, VB = 1'b0;
   logic [HW-1:0] hpos, htotal;
   logic [VW-1:0] vpos, vtotal;
   logic          active, frame_start, locked;

   int checks = 0;
   int errors = 0;

   int gx = 0, gy = 0, short_y = -1;
   int vs_seen = 0, mx_h = 0, mx_v = 0;
   bit hs_kill = 1'b0;

   jtpopeye_sync_decode #(.HW(HW), .VW(VW), .LOCK_FRAMES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .pxl_cen     (pxl_cen),
      .HS          (HS),
      .VS          (VS),
      .HB          (HB),
      .VB          (VB),
      .hpos        (hpos),
      .vpos        (vpos),
      .active      (active),
      .htotal      (htotal),
      .vtotal      (vtotal),
      .frame_start (frame_start),
      .locked      (locked)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One pixel of the raster: drive pins, one pxl_cen clk, three idle clks.
   task automatic pix();
      bit fs_now;
      HS = !hs_kill && (gx < HS_W);
      VS = (gy == 0);
      HB = (gx < HB_W);
      VB = (gy < VB_L);
      pxl_cen = 1'b1;
      @(posedge clk); #1;
      pxl_cen = 1'b0;
      fs_now = frame_start;
      if (fs_now) vs_seen++;
      if (active) begin
         if (int'(hpos) > mx_h) mx_h = int'(hpos);
         if (int'(vpos) > mx_v) mx_v = int'(vpos);
      end
      @(posedge clk); #1;
      if (fs_now) check("fs_pulse_width", int'(frame_start), 0);
      repeat (2) @(posedge clk);
      #1;
      gx++;
      if (gx >= ((gy == short_y) ? LINE - 1 : LINE)) begin
         gx = 0;
         gy = (gy + 1) % FRAME;
      end
   endtask

   task automatic to_vs();
      int c;
      int n;
      c = vs_seen;
      n = 0;
      while (vs_seen == c && n < 2 * LINE * FRAME) begin
         pix();
         n++;
      end
      if (vs_seen == c) check("vs_wait", 0, 1);
   endtask

   task automatic to_pos(input int y, input int x);
      int n;
      n = 0;
      while (!(gy == y && gx == x) && n < 2000) begin
         pix();
         n++;
      end
      if (n >= 2000) check("pos_wait", 0, 1);
      else pix();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_hpos"},   int'(hpos),        0);
      check({tag, "_vpos"},   int'(vpos),        0);
      check({tag, "_htotal"}, int'(htotal),      0);
      check({tag, "_vtotal"}, int'(vtotal),      0);
      check({tag, "_locked"}, int'(locked),      0);
      check({tag, "_fs"},     int'(frame_start), 0);
      check({tag, "_active"}, int'(active),      0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      // Start one line into a frame so the first VS closes a full frame.
      gy = 1;
      gx = 0;
      to_vs();
      check("vs1_vtotal", int'(vtotal), 20);
      check("vs1_htotal", int'(htotal), 40);
      check("vs1_locked", int'(locked), 0);
      to_vs();
      check("vs2_locked", int'(locked), 0);
      mx_h = 0;
      mx_v = 0;
      to_vs();
      check("vs3_locked", int'(locked), 1);
      check("max_hpos",   mx_h, 31);
      check("max_vpos",   mx_v, 15);

      // Position mid-frame, then freeze pxl_cen while pins toggle.
      to_pos(10, 20);
      check("pos_hpos",   int'(hpos),   12);
      check("pos_vpos",   int'(vpos),   6);
      check("pos_active", int'(active), 1);
      for (int i = 0; i < 40; i++) begin
         HS = 1'($urandom);
         VS = 1'($urandom);
         HB = 1'($urandom);
         VB = 1'($urandom);
         @(posedge clk); #1;
      end
      check("frz_hpos",   int'(hpos),   12);
      check("frz_vpos",   int'(vpos),   6);
      check("frz_htotal", int'(htotal), 40);
      check("frz_vtotal", int'(vtotal), 20);
      check("frz_locked", int'(locked), 1);
      to_vs();
      check("vs4_locked", int'(locked), 1);
      check("vs4_vtotal", int'(vtotal), 20);

      // One 39-pixel line while locked.
      short_y = 10;
      to_pos(11, 0);
      short_y = -1;
      check("short_htotal", int'(htotal), 39);
      check("short_locked", int'(locked), 1);
      to_vs();
      check("err_locked", int'(locked), 0);
      check("err_vtotal", int'(vtotal), 20);
      to_vs();
      check("relock1", int'(locked), 0);
      to_vs();
      check("relock2", int'(locked), 0);
      to_vs();
      check("relock3", int'(locked), 1);

      // One-clk reset in the middle of a locked frame.
      to_pos(10, 20);
      check("pre_rst_locked", int'(locked), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_zero("midrst");
      to_vs();
      check("rst_vs1_vtotal", int'(vtotal), 10);
      check("rst_vs1_locked", int'(locked), 0);
      to_vs();
      check("rst_vs2_locked", int'(locked), 0);
      to_vs();
      check("rst_vs3_locked", int'(locked), 0);
      to_vs();
      check("rst_vs4_locked", int'(locked), 1);

      // HS disappears: lock must drop once the pixel counter pins at 511.
      to_pos(2, 0);
      hs_kill = 1'b1;
      repeat (500) pix();
      check("to_500_locked", int'(locked), 1);
      repeat (20) pix();
      check("to_520_locked", int'(locked), 0);
      check("to_htotal",     int'(htotal), 40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
